tdm_frame_sched: RTL and testbench

TDM_FRAME_SCHED -- requirements
Module: tdm_frame_sched

---
 rtl/tdm_sched_pkg.sv | 8 +
 rtl/tdm_frame_sched_if.sv | 21 ++
 rtl/rr_arb8.sv | 23 ++
 rtl/tdm_frame_sched.sv | 61 ++++++
 tb/tb_tdm_frame_sched.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tdm_sched_pkg.sv
// tdm_sched_pkg: shared sizes and assembly FSM states for the TDM frame scheduler
package tdm_sched_pkg;
  localparam int NCH = 8;
  localparam int SAMPLE_W = 32;
  localparam int FRAME_W = NCH * SAMPLE_W;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
endpackage

// File: rtl/tdm_frame_sched_if.sv
// tdm_frame_sched_if: channel/frame bus of the TDM scheduler; underrunCnt exists only with TDM_SCHED_STATS_EN
interface tdm_frame_sched_if #(parameter int CNT_W = 16);
  import tdm_sched_pkg::*;
  logic enable;
  logic [NCH-1:0] chMask;
  logic [NCH-1:0] chReq;
  logic [FRAME_W-1:0] chData;
  logic [NCH-1:0] chGnt;
  logic valid;
  logic ack;
  logic [FRAME_W-1:0] pdata;
  logic underrun;
`ifdef TDM_SCHED_STATS_EN
  logic [CNT_W-1:0] underrunCnt;
  modport master (output enable, chMask, chReq, chData, ack, input chGnt, valid, pdata, underrun, underrunCnt);
  modport slave (input enable, chMask, chReq, chData, ack, output chGnt, valid, pdata, underrun, underrunCnt);
`else
  modport master (output enable, chMask, chReq, chData, ack, input chGnt, valid, pdata, underrun);
  modport slave (input enable, chMask, chReq, chData, ack, output chGnt, valid, pdata, underrun);
`endif
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter, search starts at ptr; one-hot gnt plus its index
module rr_arb8
  import tdm_sched_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NCH-1:0]   gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // walk from farthest to nearest so the slot closest to ptr wins
    for (int k = NCH - 1; k >= 0; k--)
      if (req[ptr + IDX_W'(k)]) begin
        idx = ptr + IDX_W'(k);
        any = 1'b1;
      end
    gnt = '0;
    gnt[idx] = any;
  end
endmodule

// File: rtl/tdm_frame_sched.sv
// tdm_frame_sched: assembles per-channel samples into double-buffered TDM frames
// Optional saturating underrun counter enabled by TDM_SCHED_STATS_EN.
module tdm_frame_sched
  import tdm_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rstn,
  tdm_frame_sched_if.slave bus
);
  state_t state, state_nx;
  logic [NCH-1:0] filled, act_mask, elig, gnt;
  logic [IDX_W-1:0] rr_ptr, idx;
  logic [FRAME_W-1:0] abuf, obuf;
  logic any, valid, underrun, xfer, latch;
  rr_arb8 u_arb (.req(elig), .ptr(rr_ptr), .gnt(gnt), .idx(idx), .any(any));
  always_comb begin
    elig = (bus.enable && state == FILL) ? bus.chReq & act_mask & ~filled : '0;
    xfer = bus.enable && state == FULL && (!valid || bus.ack);
    latch = bus.enable && (state == IDLE || xfer);
    state_nx = !bus.enable ? IDLE :
               state == IDLE ? (|bus.chMask ? FILL : IDLE) :
               state == FILL ? (((filled | gnt) == act_mask) ? FULL : FILL) :
               xfer ? (|bus.chMask ? FILL : IDLE) : FULL;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      filled <= '0;
      act_mask <= '0;
      rr_ptr <= '0;
      abuf <= '0;
      obuf <= '0;
      valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= bus.ack && !valid;
      if (latch) act_mask <= bus.chMask;
      // a fresh frame starts all-zero so unselected slots read as silence
      if (latch) abuf <= '0;
      else if (any) abuf[idx*SAMPLE_W +: SAMPLE_W] <= bus.chData[idx*SAMPLE_W +: SAMPLE_W];
      if (xfer) obuf <= abuf;
      filled <= (!bus.enable || xfer) ? '0 : filled | gnt;
      rr_ptr <= !bus.enable ? '0 : any ? idx + 1'b1 : rr_ptr;
      valid <= !bus.enable ? 1'b0 : xfer ? 1'b1 : bus.ack ? 1'b0 : valid;
    end
`ifdef TDM_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (bus.ack && !valid && cnt != '1) cnt <= cnt + 1'b1;
  assign bus.underrunCnt = cnt;
`endif
  assign bus.chGnt = gnt;
  assign bus.valid = valid;
  assign bus.pdata = obuf;
  assign bus.underrun = underrun;
endmodule

// File: tb/tb_tdm_frame_sched.sv
// tb_tdm_frame_sched: directed table-driven bench for tdm_frame_sched (CNT_W=4)
module tb_tdm_frame_sched;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  tdm_frame_sched_if #(.CNT_W(4)) bus ();
  tdm_frame_sched #(.CNT_W(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [1:0] dsel;
    logic [7:0] gnt;
    logic       vld;
    logic [1:0] psel;
  } vec_t;
  vec_t tv[23];
  function automatic logic [255:0] frame(input logic [7:0] base);
    logic [255:0] f = '0;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = 32'(base) + 32'(i);
    return f;
  endfunction
  function automatic logic [255:0] pick(input logic [1:0] sel);
    return sel == 2'd0 ? 256'd0 : sel == 2'd1 ? frame(8'hA0) : frame(8'hB0);
  endfunction
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [255:0] exp_c;
    bus.enable = 1'b1;
    bus.chMask = 8'hFF;
    bus.chReq = 8'hFF;
    bus.chData = frame(8'hA0);
    bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", 256'(bus.chGnt), 256'd0);
    chk("rst_valid", 256'(bus.valid), 256'd0);
    chk("rst_pdata", bus.pdata, 256'd0);
    chk("rst_underrun", 256'(bus.underrun), 256'd0);
`ifdef TDM_SCHED_STATS_EN
    chk("rst_cnt", 256'(bus.underrunCnt), 256'd0);
`endif
    nxt();
    bus.enable = 1'b0;
    rstn = 1'b1;
    nxt();
    bus.ack = 1'b1;
    nxt();
    bus.ack = 1'b0;
    #1;
    chk("ur_pulse", 256'(bus.underrun), 256'd1);
    chk("ur_pdata", bus.pdata, 256'd0);
    chk("ur_valid", 256'(bus.valid), 256'd0);
`ifdef TDM_SCHED_STATS_EN
    chk("ur_cnt", 256'(bus.underrunCnt), 256'd1);
`endif
    nxt();
    #1;
    chk("ur_once", 256'(bus.underrun), 256'd0);
    tv[0] = '{8'hFF, 1'b0, 2'd1, 8'h00, 1'b0, 2'd0};
    for (int i = 1; i <= 8; i++) tv[i] = '{8'hFF, 1'b0, 2'd1, 8'(1 << (i - 1)), 1'b0, 2'd0};
    tv[9] = '{8'h00, 1'b0, 2'd1, 8'h00, 1'b0, 2'd0};
    tv[10] = '{8'h00, 1'b0, 2'd1, 8'h00, 1'b1, 2'd1};
    for (int i = 11; i <= 18; i++) tv[i] = '{8'hFF, 1'b0, 2'd2, 8'(1 << (i - 11)), 1'b1, 2'd1};
    tv[19] = '{8'h00, 1'b0, 2'd2, 8'h00, 1'b1, 2'd1};
    tv[20] = '{8'h00, 1'b1, 2'd2, 8'h00, 1'b1, 2'd1};
    tv[21] = '{8'h00, 1'b1, 2'd2, 8'h00, 1'b1, 2'd2};
    tv[22] = '{8'h00, 1'b0, 2'd2, 8'h00, 1'b0, 2'd2};
    for (int i = 0; i < 23; i++) begin
      nxt();
      bus.enable = 1'b1;
      bus.chMask = 8'hFF;
      bus.chReq = tv[i].req;
      bus.ack = tv[i].ack;
      bus.chData = tv[i].dsel == 2'd1 ? frame(8'hA0) : frame(8'hB0);
      #1;
      chk($sformatf("tv%0d_gnt", i), 256'(bus.chGnt), 256'(tv[i].gnt));
      chk($sformatf("tv%0d_valid", i), 256'(bus.valid), 256'(tv[i].vld));
      chk($sformatf("tv%0d_pdata", i), bus.pdata, pick(tv[i].psel));
      chk($sformatf("tv%0d_underrun", i), 256'(bus.underrun), 256'd0);
    end
    nxt();
    bus.chReq = 8'hFF;
    #1;
    chk("en_g0", 256'(bus.chGnt), 256'h01);
    nxt();
    #1;
    chk("en_g1", 256'(bus.chGnt), 256'h02);
    nxt();
    #1;
    chk("en_g2", 256'(bus.chGnt), 256'h04);
    nxt();
    bus.enable = 1'b0;
    #1;
    chk("en_off_gnt", 256'(bus.chGnt), 256'd0);
    nxt();
    #1;
    chk("en_off_gnt2", 256'(bus.chGnt), 256'd0);
    chk("en_off_valid", 256'(bus.valid), 256'd0);
    chk("en_off_pdata", bus.pdata, frame(8'hB0));
    nxt();
    bus.enable = 1'b1;
    #1;
    chk("reen_idle", 256'(bus.chGnt), 256'd0);
    nxt();
    #1;
    chk("reen_ch0", 256'(bus.chGnt), 256'h01);
    nxt();
    bus.enable = 1'b0;
    bus.chReq = 8'h00;
    nxt();
    bus.enable = 1'b1;
    bus.chMask = 8'h05;
    bus.chReq = 8'h04;
    bus.chData = frame(8'hC0);
    #1;
    chk("m5_idle", 256'(bus.chGnt), 256'd0);
    nxt();
    #1;
    chk("m5_g2", 256'(bus.chGnt), 256'h04);
    nxt();
    bus.chReq = 8'h01;
    #1;
    chk("m5_g0", 256'(bus.chGnt), 256'h01);
    nxt();
    bus.chReq = 8'h00;
    bus.chMask = 8'h00;
    #1;
    chk("m5_full_gnt", 256'(bus.chGnt), 256'd0);
    chk("m5_full_valid", 256'(bus.valid), 256'd0);
    nxt();
    #1;
    exp_c = '0;
    exp_c[31:0] = 32'hC0;
    exp_c[95:64] = 32'hC2;
    chk("m5_valid", 256'(bus.valid), 256'd1);
    chk("m5_pdata", bus.pdata, exp_c);
    nxt();
    bus.enable = 1'b1;
    bus.chMask = 8'hFF;
    bus.chReq = 8'hFF;
    nxt();
    nxt();
    #1;
    rstn = 1'b0;
    #1;
    chk("mrst_gnt", 256'(bus.chGnt), 256'd0);
    chk("mrst_valid", 256'(bus.valid), 256'd0);
    chk("mrst_pdata", bus.pdata, 256'd0);
    nxt();
    rstn = 1'b1;
    #1;
    chk("mrst_rel_gnt", 256'(bus.chGnt), 256'd0);
    nxt();
    #1;
    chk("mrst_first", 256'(bus.chGnt), 256'h01);
    nxt();
    bus.enable = 1'b0;
    bus.ack = 1'b1;
    repeat (21) nxt();
    bus.ack = 1'b0;
    #1;
    chk("sat_pulse", 256'(bus.underrun), 256'd1);
`ifdef TDM_SCHED_STATS_EN
    chk("sat_cnt", 256'(bus.underrunCnt), 256'hF);
`endif
    nxt();
    #1;
    chk("sat_end", 256'(bus.underrun), 256'd0);
`ifdef TDM_SCHED_STATS_EN
    chk("sat_hold", 256'(bus.underrunCnt), 256'hF);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
